ca_row_generator: RTL and testbench

- Framebuffer writer for the cellular-automaton display.
- Fills the 1280x1024 one-bit-per-pixel framebuffer (65536 words x 20 bits, dual-port RAM port A) with successive generations of a 1-D elementary CA. Row 0 is a seed; row r is computed from row r-1, read back from the same RAM.
- The VGA scan-out stage reads port B and pulses ready_sig at frame end. Generation starts only on that pulse.

---
 rtl/ca_pkg.sv | 22 ++
 rtl/ca_seed_lfsr.sv | 18 +
 rtl/ca_row_generator.sv | 165 ++++++++++++++++
 tb/tb_ca_row_generator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared types and the combinational next-generation function for the CA framebuffer writer.
package ca_pkg;

    localparam int WORD_W        = 20;
    localparam int WORDS_PER_ROW = 64;
    localparam int ROWS          = 1024;

    typedef enum logic [2:0] {IDLE, ARM, SEED, PRIME, RD, CAP, WR} gen_state_t;

    // Bit 0 is the leftmost pixel, so bit i's left neighbour is bit i-1.
    function automatic logic [WORD_W-1:0] ca_word(input logic [7:0] rule, input logic left_bit,
                                                  input logic [WORD_W-1:0] word, input logic right_bit);
        logic [WORD_W+1:0] ext;
        logic [WORD_W-1:0] res;
        ext = {right_bit, word, left_bit};
        res = '0;
        for (int i = 0; i < WORD_W; i++)
            res[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
        return res;
    endfunction

endpackage

// File: rtl/ca_seed_lfsr.sv
// 20-bit Fibonacci LFSR (x^20+x^17+1) supplying random seed rows.
module ca_seed_lfsr #(
    parameter logic [19:0] SEED = 20'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [19:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= SEED;
        else if (step)
            value <= {value[18:0], value[19] ^ value[16]};
    end

endmodule

// File: rtl/ca_row_generator.sv
// Writes successive 1-D CA generations into the framebuffer, reading each
// previous row back through RAM port A.
module ca_row_generator #(
    parameter bit          WRAP          = 1'b0,
    parameter logic [19:0] LFSR_SEED     = 20'hACE1,
    parameter int          WORDS_PER_ROW = 64,
    parameter int          ROWS          = 1024
) (
    input  logic        clk108,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rule,
    input  logic        seed_sel,
    input  logic        ready_sig,
    input  logic [19:0] q_a,
    output logic [15:0] address_a,
    output logic [19:0] data_a,
    output logic        wren_a,
    output logic        busy,
    output logic        done
);
    import ca_pkg::*;

    localparam int CW = $clog2(WORDS_PER_ROW);
    localparam int RW = $clog2(ROWS);

    gen_state_t      state, state_nxt;
    logic [7:0]      rule_q;
    logic            sel_q;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [1:0]      phase;
    logic            prev_bit, first_bit;
    logic [19:0]     cur_w, nxt_w;
    logic [19:0]     lfsr_val;
    logic            col_last, col_nxt_last, row_last, prime_last, right_bit;
    logic [15:0]     src_row, dst_row;

    function automatic logic [15:0] word_addr(input logic [15:0] r, input logic [15:0] k);
        return r * 16'(WORDS_PER_ROW) + k;
    endfunction

    assign col_last     = (col == CW'(WORDS_PER_ROW - 1));
    assign col_nxt_last = (col == CW'(WORDS_PER_ROW - 2));
    assign row_last     = (row == RW'(ROWS - 1));
    assign prime_last   = WRAP ? (phase == 2'd3) : (phase == 2'd1);
    assign dst_row      = 16'(row);
    assign src_row      = dst_row - 16'd1;
    assign right_bit    = col_last ? (WRAP ? first_bit : 1'b0) : nxt_w[0];
    assign busy         = (state != IDLE);

    ca_seed_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk108),
        .rst   (reset),
        .step  (state == SEED && sel_q),
        .value (lfsr_val)
    );

    always_comb begin
        state_nxt = state;
        address_a = '0;
        data_a    = '0;
        wren_a    = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ARM;
            ARM:   if (ready_sig) state_nxt = SEED;
            SEED: begin
                wren_a    = 1'b1;
                address_a = 16'(col);
                if (sel_q)
                    data_a = lfsr_val;
                else if (col == CW'(WORDS_PER_ROW / 2))
                    data_a = 20'h00001;
                if (col_last) state_nxt = PRIME;
            end
            PRIME: begin
                // Wrap mode fetches the last word first so its bit 19 feeds pixel 0.
                address_a = word_addr(src_row, (WRAP && !phase[1]) ? 16'(WORDS_PER_ROW - 1) : 16'd0);
                if (prime_last) state_nxt = col_last ? WR : RD;
            end
            RD: begin
                address_a = word_addr(src_row, 16'(col) + 16'd1);
                state_nxt = CAP;
            end
            CAP: begin
                address_a = word_addr(src_row, 16'(col) + 16'd1);
                state_nxt = WR;
            end
            WR: begin
                wren_a    = 1'b1;
                address_a = word_addr(dst_row, 16'(col));
                data_a    = ca_word(rule_q, prev_bit, cur_w, right_bit);
                if (col_last)
                    state_nxt = row_last ? IDLE : PRIME;
                else
                    state_nxt = col_nxt_last ? WR : RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk108 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rule_q    <= '0;
            sel_q     <= 1'b0;
            row       <= '0;
            col       <= '0;
            phase     <= '0;
            prev_bit  <= 1'b0;
            first_bit <= 1'b0;
            cur_w     <= '0;
            nxt_w     <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == WR) && col_last && row_last;
            case (state)
                IDLE: if (start) begin
                    rule_q <= rule;
                    sel_q  <= seed_sel;
                end
                ARM: begin
                    row <= '0;
                    col <= '0;
                end
                SEED: begin
                    phase <= '0;
                    if (col_last) begin
                        col <= '0;
                        row <= RW'(1);
                    end else
                        col <= col + 1'b1;
                end
                PRIME: begin
                    phase <= prime_last ? 2'd0 : phase + 2'd1;
                    if (phase == 2'd1) begin
                        if (WRAP)
                            prev_bit <= q_a[19];
                        else begin
                            cur_w    <= q_a;
                            prev_bit <= 1'b0;
                        end
                    end
                    if (phase == 2'd3) begin
                        cur_w     <= q_a;
                        first_bit <= q_a[0];
                    end
                end
                CAP: nxt_w <= q_a;
                WR: begin
                    prev_bit <= cur_w[19];
                    cur_w    <= nxt_w;
                    if (col_last) begin
                        col <= '0;
                        if (!row_last) row <= row + 1'b1;
                    end else
                        col <= col + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_row_generator.sv
// Drives a clamped-edge and a toroidal generator side by side against RAM
// models and compares each finished frame with a pixel-level CA reference.
module tb_ca_row_generator;

    localparam int NW = 4;
    localparam int NR = 64;
    localparam int NP = NW * 20;
    localparam int LASTA = NR * NW - 1;
    localparam logic [19:0] SEEDV = 20'hACE1;
    localparam logic [19:0] SENT  = 20'h5A5A5;

    logic        clk108 = 1'b0;
    logic        reset = 1'b1, start = 1'b0, seed_sel = 1'b0, ready_sig = 1'b0, clr = 1'b0;
    logic [7:0]  rule = 8'h00;
    logic [19:0] q_a [2];
    logic [19:0] data_a [2];
    logic [15:0] address_a [2];
    logic        wren_a [2];
    logic        busy [2];
    logic        done [2];

    logic [19:0] mem0 [0:65535];
    logic [19:0] mem1 [0:65535];
    logic [19:0] expm [2][NR][NW];
    logic [19:0] lfsr_m;

    int checks = 0, fails = 0;
    int done_cnt [2];
    int done_bad [2];
    int wr_cnt [2];
    bit had_wr [2];
    logic [15:0] last_wr [2];

    always #5 clk108 = ~clk108;

    ca_row_generator #(.WRAP(1'b0), .LFSR_SEED(SEEDV), .WORDS_PER_ROW(NW), .ROWS(NR)) dut0 (
        .clk108(clk108), .reset(reset), .start(start), .rule(rule), .seed_sel(seed_sel),
        .ready_sig(ready_sig), .q_a(q_a[0]), .address_a(address_a[0]), .data_a(data_a[0]),
        .wren_a(wren_a[0]), .busy(busy[0]), .done(done[0]));

    ca_row_generator #(.WRAP(1'b1), .LFSR_SEED(SEEDV), .WORDS_PER_ROW(NW), .ROWS(NR)) dut1 (
        .clk108(clk108), .reset(reset), .start(start), .rule(rule), .seed_sel(seed_sel),
        .ready_sig(ready_sig), .q_a(q_a[1]), .address_a(address_a[1]), .data_a(data_a[1]),
        .wren_a(wren_a[1]), .busy(busy[1]), .done(done[1]));

    always @(posedge clk108) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) begin
                mem0[i] <= SENT;
                mem1[i] <= SENT;
            end
        end else begin
            if (wren_a[0]) mem0[address_a[0]] <= data_a[0];
            if (wren_a[1]) mem1[address_a[1]] <= data_a[1];
        end
        q_a[0] <= mem0[address_a[0]];
        q_a[1] <= mem1[address_a[1]];
    end

    // done must follow the write of the last address by one cycle, with busy already low.
    always @(negedge clk108) begin
        for (int w = 0; w < 2; w++) begin
            if (done[w]) begin
                done_cnt[w] <= done_cnt[w] + 1;
                if (!(had_wr[w] && last_wr[w] == 16'(LASTA) && !busy[w] && !wren_a[w]))
                    done_bad[w] <= done_bad[w] + 1;
            end
            if (wren_a[w]) wr_cnt[w] <= wr_cnt[w] + 1;
            had_wr[w]  <= (wren_a[w] === 1'b1);
            last_wr[w] <= address_a[w];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] lfsr_next(input logic [19:0] v);
        int x;
        x = int'(v);
        return 20'(((x * 2) % (1 << 20)) + (((x >> 19) ^ (x >> 16)) & 1));
    endfunction

    function automatic logic [19:0] rd(input int w, input int a);
        return (w == 1) ? mem1[a] : mem0[a];
    endfunction

    task automatic build_model(input logic [7:0] rl, input bit sel);
        bit px [NP];
        bit nx [NP];
        logic [19:0] sw [NW];
        int l, c, r;
        for (int k = 0; k < NW; k++) begin
            sw[k] = sel ? lfsr_m : ((k == NW / 2) ? 20'h00001 : 20'h00000);
            if (sel) lfsr_m = lfsr_next(lfsr_m);
        end
        for (int wr = 0; wr < 2; wr++) begin
            for (int p = 0; p < NP; p++) px[p] = sw[p / 20][p % 20];
            for (int row = 0; row < NR; row++) begin
                for (int p = 0; p < NP; p++) expm[wr][row][p / 20][p % 20] = px[p];
                for (int p = 0; p < NP; p++) begin
                    l = (p == 0) ? ((wr == 1) ? int'(px[NP-1]) : 0) : int'(px[p-1]);
                    c = int'(px[p]);
                    r = (p == NP - 1) ? ((wr == 1) ? int'(px[0]) : 0) : int'(px[p+1]);
                    nx[p] = rl[l * 4 + c * 2 + r];
                end
                px = nx;
            end
        end
    endtask

    task automatic clear_mem();
        @(negedge clk108) clr = 1'b1;
        @(negedge clk108) clr = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] rl, input bit sel, input bit long_arm);
        int bd0, bd1, bb0, bb1, bw, n;
        logic [127:0] got, exp;
        build_model(rl, sel);
        clear_mem();
        bd0 = done_cnt[0]; bd1 = done_cnt[1];
        bb0 = done_bad[0]; bb1 = done_bad[1];
        bw  = wr_cnt[0] + wr_cnt[1];
        @(negedge clk108);
        start = 1'b1; rule = rl; seed_sel = sel; ready_sig = long_arm;
        @(negedge clk108);
        start = 1'b0; ready_sig = 1'b0; rule = ~rl; seed_sel = ~sel;
        chk("busy_after_start", {busy[0], busy[1]}, 2'b11);
        if (long_arm) begin
            repeat (5000) @(negedge clk108);
            start = 1'b1;
            @(negedge clk108) start = 1'b0;
            repeat (4999) @(negedge clk108);
            chk("busy_long_arm", {busy[0], busy[1]}, 2'b11);
        end else
            repeat ($urandom_range(1, 6)) @(negedge clk108);
        chk("arm_no_write", 128'(wr_cnt[0] + wr_cnt[1] - bw), 128'(0));
        ready_sig = 1'b1;
        @(negedge clk108) ready_sig = 1'b0;
        chk("first_write", {wren_a[0], wren_a[1], address_a[0], address_a[1]}, {1'b1, 1'b1, 32'h0});
        repeat (20) @(negedge clk108);
        start = 1'b1; rule = 8'hA5;
        @(negedge clk108) start = 1'b0;
        n = 0;
        while ((done_cnt[0] == bd0 || done_cnt[1] == bd1) && n < NR * 20 + 200) begin
            @(negedge clk108);
            n++;
        end
        chk("done_timeout", 128'(n < NR * 20 + 200), 128'(1));
        repeat (5) @(negedge clk108);
        chk("done_once", {32'(done_cnt[0] - bd0), 32'(done_cnt[1] - bd1)}, {32'd1, 32'd1});
        chk("done_after_last", {32'(done_bad[0] - bb0), 32'(done_bad[1] - bb1)}, 64'd0);
        chk("idle_after", {busy[0], busy[1], wren_a[0], wren_a[1]}, 4'b0);
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < NR; r++) begin
                got = '0; exp = '0;
                for (int k = 0; k < NW; k++) begin
                    got[k*20 +: 20] = rd(w, r * NW + k);
                    exp[k*20 +: 20] = expm[w][r][k];
                end
                chk($sformatf("rule%0d_w%0d_row%0d", rl, w, r), got, exp);
            end
        chk("beyond_frame", {rd(0, LASTA + 1), rd(1, LASTA + 1)}, {SENT, SENT});
    endtask

    initial begin
        logic [19:0] acc;
        int n;
        repeat (3) @(negedge clk108);
        chk("reset_state", {address_a[0], data_a[0], wren_a[0], busy[0], done[0],
                            address_a[1], data_a[1], wren_a[1], busy[1], done[1]}, 128'(0));
        reset = 1'b0;
        lfsr_m = SEEDV;

        run_frame(8'd90, 1'b0, 1'b1);
        chk("r90_row1_left",  rd(0, NW + NW / 2 - 1), 20'h80000);
        chk("r90_row1_right", rd(0, NW + NW / 2), 20'h00002);
        chk("r90_row2_left",  rd(0, 2 * NW + NW / 2 - 1), 20'h40000);
        chk("r90_row2_right", rd(0, 2 * NW + NW / 2), 20'h00004);

        run_frame(8'd0, 1'b0, 1'b0);
        acc = '0;
        for (int a = NW; a <= LASTA; a++) acc = acc | mem0[a] | mem1[a];
        chk("r0_seed", rd(0, NW / 2), 20'h00001);
        chk("r0_all_zero", acc, 20'h0);

        run_frame(8'd255, 1'b0, 1'b0);
        acc = 20'hFFFFF;
        for (int a = NW; a <= LASTA; a++) acc = acc & mem0[a] & mem1[a];
        chk("r255_all_ones", acc, 20'hFFFFF);

        run_frame(8'd2, 1'b0, 1'b0);
        chk("r2_clamp_edge", rd(0, (NP / 2) * NW), 20'h00001);
        acc = '0;
        for (int k = 0; k < NW; k++) acc = acc | rd(0, (NP / 2 + 1) * NW + k);
        chk("r2_clamp_gone", acc, 20'h0);
        chk("r2_wrap_edge", rd(1, (NP / 2 + 1) * NW + NW - 1), 20'h80000);

        // Abort mid-frame, then the next request must regenerate from row 0 with a fresh LFSR.
        clear_mem();
        @(negedge clk108) begin start = 1'b1; rule = 8'd30; seed_sel = 1'b1; end
        @(negedge clk108) start = 1'b0;
        @(negedge clk108) ready_sig = 1'b1;
        @(negedge clk108) ready_sig = 1'b0;
        n = 0;
        while (!(wren_a[0] && address_a[0] == 16'(30 * NW + 2)) && n < NR * 20) begin
            @(negedge clk108);
            n++;
        end
        chk("abort_point_reached", 128'(n < NR * 20), 128'(1));
        #1 reset = 1'b1;
        #1 chk("reset_abort", {wren_a[0], wren_a[1], busy[0], busy[1], done[0], done[1], address_a[0]}, 128'(0));
        repeat (2) @(negedge clk108);
        reset = 1'b0;
        lfsr_m = SEEDV;

        run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        chk("lfsr_word0", {rd(0, 0), rd(1, 0)}, {SEEDV, SEEDV});
        chk("lfsr_word1", rd(0, 1), lfsr_next(SEEDV));

        repeat (4) run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
